// File: rtl/ddr_sched_pkg.sv
// Shared state encoding, grant constants and pointer helper for the DDR ring scheduler.
package ddr_sched_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARB     = 3'd1,
      WR_REQ  = 3'd2,
      WR_WAIT = 3'd3,
      RD_REQ  = 3'd4,
      RD_WAIT = 3'd5
   } sched_state_e;

   localparam logic GRANT_RD = 1'b0;
   localparam logic GRANT_WR = 1'b1;

   // Advance a ring pointer by step, folding back to 0 at the ring boundary.
   function automatic logic [31:0] ptr_wrap(input logic [31:0] ptr,
                                            input logic [31:0] step,
                                            input logic [31:0] ring_words);
      logic [31:0] nxt;
      nxt = ptr + step;
      return (nxt >= ring_words) ? nxt - ring_words : nxt;
   endfunction

endpackage

// File: rtl/ddr_ring_scheduler_if.sv
// Request/finish handshake between the ring scheduler (master) and the DDR burst controller (slave).
interface ddr_ring_scheduler_if #(parameter int ADDR_WIDTH = 30);
   logic                  burst_idle_i;
   logic                  wr_ddr_req_o;
   logic [7:0]            wr_ddr_len_o;
   logic [ADDR_WIDTH-1:0] wr_ddr_addr_o;
   logic                  wr_ddr_finish_i;
   logic                  rd_ddr_req_o;
   logic [7:0]            rd_ddr_len_o;
   logic [ADDR_WIDTH-1:0] rd_ddr_addr_o;
   logic                  rd_ddr_finish_i;

   modport master (
      input  burst_idle_i, wr_ddr_finish_i, rd_ddr_finish_i,
      output wr_ddr_req_o, wr_ddr_len_o, wr_ddr_addr_o,
      output rd_ddr_req_o, rd_ddr_len_o, rd_ddr_addr_o
   );

   modport slave (
      output burst_idle_i, wr_ddr_finish_i, rd_ddr_finish_i,
      input  wr_ddr_req_o, wr_ddr_len_o, wr_ddr_addr_o,
      input  rd_ddr_req_o, rd_ddr_len_o, rd_ddr_addr_o
   );
endinterface

// File: rtl/ring_ptr_unit.sv
// Ring write/read pointers, occupancy, flush clearing and burst address generation.
// RING_OVERWRITE_EN: a write into a full ring advances the read pointer instead of occupancy.
module ring_ptr_unit
   import ddr_sched_pkg::*;
#(
   parameter int          ADDR_WIDTH = 30,
   parameter int          BURST_LEN  = 64,
   parameter logic [31:0] RING_WORDS = 32'h0100_0000,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int          ADDR_STEP  = 8,
   parameter int          PTR_W      = 24
)(
   input  logic                  clk_sys,
   input  logic                  rst_b,
   input  logic                  flush_apply,
   input  logic                  wr_commit,
   input  logic                  rd_commit,
   output logic [PTR_W:0]        used_words,
   output logic                  ring_full,
   output logic                  rd_avail,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [ADDR_WIDTH-1:0] rd_addr
);

   localparam logic [31:0] BL32 = 32'(BURST_LEN);

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]        used_q, used_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [31:0]           free_words;

   assign free_words = RING_WORDS - 32'(used_q);
   assign ring_full  = free_words < BL32;
   assign rd_avail   = 32'(used_q) >= BL32;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      used_d   = used_q;
      if (flush_apply) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         used_d   = '0;
      end else if (wr_commit) begin
`ifdef RING_OVERWRITE_EN
         wr_ptr_d = PTR_W'(ptr_wrap(32'(wr_ptr_q), BL32, RING_WORDS));
         if (ring_full) rd_ptr_d = PTR_W'(ptr_wrap(32'(rd_ptr_q), BL32, RING_WORDS));
         else           used_d   = used_q + (PTR_W+1)'(BURST_LEN);
`else
         if (!ring_full) begin
            wr_ptr_d = PTR_W'(ptr_wrap(32'(wr_ptr_q), BL32, RING_WORDS));
            used_d   = used_q + (PTR_W+1)'(BURST_LEN);
         end
`endif
      end else if (rd_commit && rd_avail) begin
         rd_ptr_d = PTR_W'(ptr_wrap(32'(rd_ptr_q), BL32, RING_WORDS));
         used_d   = used_q - (PTR_W+1)'(BURST_LEN);
      end
      // Addresses trail the pointers by one cycle; the FSM never requests that soon after an update.
      wr_addr_d = ADDR_WIDTH'(BASE_ADDR + 32'(wr_ptr_q) * 32'(ADDR_STEP));
      rd_addr_d = ADDR_WIDTH'(BASE_ADDR + 32'(rd_ptr_q) * 32'(ADDR_STEP));
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         used_q    <= '0;
         wr_addr_q <= '0;
         rd_addr_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         used_q    <= used_d;
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
      end
   end

   assign used_words = used_q;
   assign wr_addr    = wr_addr_q;
   assign rd_addr    = rd_addr_q;

endmodule

// File: rtl/ddr_ring_scheduler.sv
// DDR ring scheduler: arbitrates write/read bursts between ingress and egress FIFOs over a DDR ring.
// RING_OVERWRITE_EN: when defined, writes into a full ring drop the oldest burst instead of blocking.
//
// state   | meaning
// IDLE    | waiting for burst controller idle and no flush
// ARB     | one-cycle grant decision
// WR_REQ  | write request pulse
// WR_WAIT | waiting for write finish
// RD_REQ  | read request pulse
// RD_WAIT | waiting for read finish
module ddr_ring_scheduler
   import ddr_sched_pkg::*;
#(
   parameter int          ADDR_WIDTH = 30,
   parameter int          BURST_LEN  = 64,
   parameter logic [31:0] RING_WORDS = 32'h0100_0000,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int          ADDR_STEP  = 8,
   parameter int          CNT_W      = 12,
   parameter int          WR_URGENT  = 1024,
   parameter int          PTR_W      = 24
)(
   input  logic                  ddr_clk_i,
   input  logic                  ddr_rst_n_i,
   input  logic                  flush_i,
   input  logic [CNT_W-1:0]      wr_fifo_cnt_i,
   input  logic [CNT_W-1:0]      rd_fifo_free_i,
   ddr_ring_scheduler_if.master  ddr,
   output logic [PTR_W:0]        used_words_o,
   output logic                  overflow_o,
   output logic [31:0]           drop_cnt_o,
   output logic                  busy_o
);

   localparam logic [31:0] BL32 = 32'(BURST_LEN);

   sched_state_e state_q, state_d;
   logic         last_grant_q, last_grant_d;
   logic         flush_pend_q, flush_pend_d;
   logic         overflow_q, overflow_d;
   logic [31:0]  drop_cnt_q, drop_cnt_d;

   logic flush_apply, wr_commit, rd_commit, drop_evt;
   logic ring_full, rd_avail;
   logic wr_want, wr_elig, rd_ok, urgent, grant_wr, grant_rd;

   ring_ptr_unit #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BURST_LEN  (BURST_LEN),
      .RING_WORDS (RING_WORDS),
      .BASE_ADDR  (BASE_ADDR),
      .ADDR_STEP  (ADDR_STEP),
      .PTR_W      (PTR_W)
   ) u_ring_ptr (
      .clk_sys     (ddr_clk_i),
      .rst_b       (ddr_rst_n_i),
      .flush_apply (flush_apply),
      .wr_commit   (wr_commit),
      .rd_commit   (rd_commit),
      .used_words  (used_words_o),
      .ring_full   (ring_full),
      .rd_avail    (rd_avail),
      .wr_addr     (ddr.wr_ddr_addr_o),
      .rd_addr     (ddr.rd_ddr_addr_o)
   );

   assign wr_want = 32'(wr_fifo_cnt_i) >= BL32;
`ifdef RING_OVERWRITE_EN
   assign wr_elig = wr_want;
`else
   assign wr_elig = wr_want && !ring_full;
`endif
   assign rd_ok    = rd_avail && (32'(rd_fifo_free_i) >= BL32);
   assign urgent   = 32'(wr_fifo_cnt_i) >= 32'(WR_URGENT);
   assign grant_wr = wr_elig && (urgent || !rd_ok || (last_grant_q == GRANT_RD));
   assign grant_rd = rd_ok && !grant_wr;
`ifdef RING_OVERWRITE_EN
   assign drop_evt = wr_want && ring_full && grant_wr;
`else
   assign drop_evt = wr_want && ring_full;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      flush_pend_d = flush_pend_q;
      overflow_d   = overflow_q;
      drop_cnt_d   = drop_cnt_q;
      flush_apply  = 1'b0;
      wr_commit    = 1'b0;
      rd_commit    = 1'b0;
      case (state_q)
         IDLE: begin
            if (flush_i)               flush_apply = 1'b1;
            else if (ddr.burst_idle_i) state_d     = ARB;
         end
         ARB: begin
            state_d = IDLE;
            if (flush_i) begin
               flush_apply = 1'b1;
            end else begin
               if (drop_evt) begin
                  overflow_d = 1'b1;
                  if (drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_d = drop_cnt_q + 32'd1;
               end
               if (grant_wr) begin
                  state_d      = WR_REQ;
                  last_grant_d = GRANT_WR;
               end else if (grant_rd) begin
                  state_d      = RD_REQ;
                  last_grant_d = GRANT_RD;
               end
            end
         end
         WR_REQ, RD_REQ: begin
            flush_pend_d = flush_pend_q | flush_i;
            state_d      = (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
         end
         WR_WAIT, RD_WAIT: begin
            flush_pend_d = flush_pend_q | flush_i;
            if ((state_q == WR_WAIT) ? ddr.wr_ddr_finish_i : ddr.rd_ddr_finish_i) begin
               state_d      = IDLE;
               flush_pend_d = 1'b0;
               // A flush seen at any point of the burst discards the finish update.
               if (flush_pend_q || flush_i)  flush_apply = 1'b1;
               else if (state_q == WR_WAIT)  wr_commit   = 1'b1;
               else                          rd_commit   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush_apply) overflow_d = 1'b0;
   end

   always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
      if (!ddr_rst_n_i) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_RD;
         flush_pend_q <= 1'b0;
         overflow_q   <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         flush_pend_q <= flush_pend_d;
         overflow_q   <= overflow_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign ddr.wr_ddr_req_o = (state_q == WR_REQ);
   assign ddr.rd_ddr_req_o = (state_q == RD_REQ);
   assign ddr.wr_ddr_len_o = 8'(BURST_LEN);
   assign ddr.rd_ddr_len_o = 8'(BURST_LEN);
   assign overflow_o       = overflow_q;
   assign drop_cnt_o       = drop_cnt_q;
   assign busy_o           = (state_q != IDLE);

endmodule
